count_writer: RTL and testbench

Writer side of the on-screen counter: accepts a 10-bit binary count, converts it to three BCD digits with a sequential double-dabble, and writes them into display memory at `count_addr+0` (ones), `+1` (tens) and `+2` (hundreds). The VGA bit generator reads the same three words. Writes are gated by a write-window input, normally vertical blanking, so a frame never shows mixed old and new digits.

---
 rtl/count_pkg.sv | 23 ++
 rtl/count_writer_bcd_convert.sv | 68 ++++++
 rtl/count_writer.sv | 102 ++++++++++
 tb/tb_count_writer.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_pkg.sv
// Shared types and constants for the on-screen counter writer.
// Holds the write FSM state encoding, digit geometry and memory offsets.
package count_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CONVERT = 3'd1,
    ST_WR_ONE  = 3'd2,
    ST_WR_TEN  = 3'd3,
    ST_WR_HUN  = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  localparam int NUM_DIGITS = 3;
  localparam int BCD_ITERS  = 10;
  localparam int DIGIT_W    = 4;
  localparam int MAX_VALUE  = 999;

  localparam int OFF_ONE = 0;
  localparam int OFF_TEN = 1;
  localparam int OFF_HUN = 2;

endpackage

// File: rtl/count_writer_bcd_convert.sv
// Sequential double-dabble: one shift-and-adjust iteration per cycle.
// A start pulse loads the operand; done pulses on the cycle of the final iteration.
module bcd_convert
  import count_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [9:0]  operand,
  output logic        done,
  output logic [11:0] bcd
);

  logic [9:0]  bin_q, bin_d;
  logic [11:0] bcd_q, bcd_d;
  logic [11:0] bcd_adj;
  logic [3:0]  iter_q, iter_d;
  logic        busy_q, busy_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*DIGIT_W +: DIGIT_W] =
        (bcd_q[gi*DIGIT_W +: DIGIT_W] >= 4'd5) ? bcd_q[gi*DIGIT_W +: DIGIT_W] + 4'd3
                                               : bcd_q[gi*DIGIT_W +: DIGIT_W];
    end
  endgenerate

  always_comb begin
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    iter_d = iter_q;
    busy_d = busy_q;
    done   = 1'b0;
    if (start) begin
      bin_d  = operand;
      bcd_d  = '0;
      iter_d = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Shift the adjusted {bcd, bin} pair left by one.
      bcd_d  = {bcd_adj[10:0], bin_q[9]};
      bin_d  = {bin_q[8:0], 1'b0};
      iter_d = iter_q + 4'd1;
      if (iter_q == 4'(BCD_ITERS - 1)) begin
        busy_d = 1'b0;
        done   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      busy_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      iter_q <= iter_d;
      busy_q <= busy_d;
    end
  end

  assign bcd = bcd_q;

endmodule

// File: rtl/count_writer.sv
// Writes the three BCD digits of a saturated 10-bit count into display memory,
// one word per cycle, only while the write window is open.
module count_writer
  import count_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int MAX_VALUE = count_pkg::MAX_VALUE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        value,
  input  logic              value_valid,
  output logic              value_ready,
  input  logic [ADDR_W-1:0] count_addr,
  input  logic              wr_allow,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWData,
  output logic              memWE,
  output logic              write_done
);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic                accept;
  logic [9:0]          operand;
  logic                conv_done;
  logic [11:0]         bcd;
  logic                writing;
  logic [1:0]          off;
  logic [DIGIT_W-1:0]  digit;

  assign value_ready = (state_q == ST_IDLE) && reset;
  assign accept      = value_valid && value_ready;
  assign operand     = (value > 10'(MAX_VALUE)) ? 10'(MAX_VALUE) : value;

  bcd_convert u_bcd (
    .clk     (clk),
    .reset   (reset),
    .start   (accept),
    .operand (operand),
    .done    (conv_done),
    .bcd     (bcd)
  );

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    writing    = 1'b0;
    off        = 2'(OFF_ONE);
    digit      = '0;
    write_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          base_d  = count_addr;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: if (conv_done) state_d = ST_WR_ONE;
      ST_WR_ONE: begin
        writing = 1'b1;
        off     = 2'(OFF_ONE);
        digit   = bcd[3:0];
        if (wr_allow) state_d = ST_WR_TEN;
      end
      ST_WR_TEN: begin
        writing = 1'b1;
        off     = 2'(OFF_TEN);
        digit   = bcd[7:4];
        if (wr_allow) state_d = ST_WR_HUN;
      end
      ST_WR_HUN: begin
        writing = 1'b1;
        off     = 2'(OFF_HUN);
        digit   = bcd[11:8];
        if (wr_allow) state_d = ST_DONE;
      end
      ST_DONE: begin
        write_done = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A reset edge must not also commit the word on the bus.
  assign memWE    = writing && wr_allow && reset;
  assign memAddr  = writing ? base_q + ADDR_W'(off) : '0;
  assign memWData = writing ? {{(DATA_W-DIGIT_W){1'b0}}, digit} : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

endmodule

// File: tb/tb_count_writer.sv
// Self-checking bench for count_writer: a transaction-level model predicts every
// output each cycle, and literal expectations pin latency and memory contents.
module tb_count_writer;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  value;
  logic        value_valid;
  logic        value_ready;
  logic [15:0] count_addr;
  logic        wr_allow;
  logic [15:0] memAddr;
  logic [15:0] memWData;
  logic        memWE;
  logic        write_done;

  count_writer #(.ADDR_W(16), .DATA_W(16), .MAX_VALUE(999)) dut (
    .clk         (clk),
    .reset       (reset),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .count_addr  (count_addr),
    .wr_allow    (wr_allow),
    .memAddr     (memAddr),
    .memWData    (memWData),
    .memWE       (memWE),
    .write_done  (write_done)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  bit chk_en  = 0;

  // Model: an update is "busy" for 10 convert cycles, then walks digit index 0..2
  // (advancing only when the window is open), then one done cycle.
  bit          m_busy = 0;
  int          m_conv = 0;
  int          m_idx  = 0;
  logic [15:0] m_base = '0;
  int          m_dig [3];
  bit          m_acc  = 0;
  int          m_acc_cyc = 0;

  typedef struct { int e; logic [15:0] a; logic [15:0] d; } wr_t;
  wr_t wlog[$];
  int  done_edge = -1;
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 16'hDEAD;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    int sv;
    cyc++;
    m_acc = 0;
    if (!reset) begin
      m_busy = 0;
    end else if (!m_busy) begin
      if (value_valid) begin
        sv        = (value > 10'd999) ? 999 : int'(value);
        m_dig[0]  = sv % 10;
        m_dig[1]  = (sv / 10) % 10;
        m_dig[2]  = sv / 100;
        m_base    = count_addr;
        m_busy    = 1;
        m_conv    = 10;
        m_idx     = 0;
        m_acc     = 1;
        m_acc_cyc = cyc;
      end
    end else if (m_conv > 0) begin
      m_conv--;
    end else if (m_idx < 3) begin
      if (wr_allow) m_idx++;
    end else begin
      m_busy = 0;
    end
  end

  logic        e_writing;
  logic [15:0] e_addr, e_data;
  always @(negedge clk) begin
    if (chk_en) begin
      e_writing = m_busy && m_conv == 0 && m_idx < 3;
      e_addr    = e_writing ? 16'(m_base + 16'(m_idx)) : 16'h0;
      e_data    = e_writing ? 16'(m_dig[m_idx]) : 16'h0;
      chk("value_ready", value_ready, !m_busy && reset);
      chk("memWE", memWE, e_writing && wr_allow && reset);
      chk("memAddr", memAddr, e_addr);
      chk("memWData", memWData, e_data);
      chk("write_done", write_done, m_busy && m_conv == 0 && m_idx == 3);
      if (memWE === 1'b1) begin
        mem[memAddr] = memWData;
        wlog.push_back('{cyc + 1, memAddr, memWData});
        $display("write edge=%0d addr=%h data=%0d", cyc + 1, memAddr, memWData);
      end
      if (write_done === 1'b1) done_edge = cyc + 1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [9:0] v, input logic [15:0] base, output int t);
    int g;
    value       = v;
    count_addr  = base;
    value_valid = 1'b1;
    g = 0;
    do begin step(); g++; end while (!m_acc && g < 40);
    if (!m_acc) begin
      n_total++; n_bad++;
      $display("FAIL accept_timeout: value %0d not taken within %0d cycles", v, g);
    end
    value_valid = 1'b0;
    t = m_acc_cyc;
    $display("accept value=%0d base=%h edge=%0d", v, base, t);
  endtask

  task automatic wait_idle(input int drop);
    int g;
    bit dropped;
    g = 0;
    dropped = 0;
    while (m_busy && g < 80) begin
      step(); g++;
      if (drop > 0 && !dropped && m_idx == 1 && m_conv == 0) begin
        wr_allow = 1'b0;
        repeat (drop) step();
        wr_allow = 1'b1;
        dropped = 1;
      end
    end
    if (m_busy) begin
      n_total++; n_bad++;
      $display("FAIL idle_timeout: update still busy after %0d cycles", g);
    end
    repeat (2) step();
  endtask

  initial begin
    int t1, t2;
    reset       = 1'b0;
    value       = '0;
    value_valid = 1'b0;
    count_addr  = '0;
    wr_allow    = 1'b1;
    step();
    chk_en = 1;
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("ready_after_reset", value_ready, 1'b1);

    // 372 @ 0400: exact latency and order.
    wlog.delete(); done_edge = -1;
    accept(10'd372, 16'h0400, t1);
    wait_idle(0);
    chk("t1_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("t1_w0_edge", wlog[0].e, t1 + 11);
      chk("t1_w0_addr", wlog[0].a, 16'h0400);
      chk("t1_w0_data", wlog[0].d, 16'd2);
      chk("t1_w1_edge", wlog[1].e, t1 + 12);
      chk("t1_w1_addr", wlog[1].a, 16'h0401);
      chk("t1_w1_data", wlog[1].d, 16'd7);
      chk("t1_w2_edge", wlog[2].e, t1 + 13);
      chk("t1_w2_addr", wlog[2].a, 16'h0402);
      chk("t1_w2_data", wlog[2].d, 16'd3);
    end
    chk("t1_done_edge", done_edge, t1 + 14);

    // Saturation and zero.
    accept(10'd1023, 16'h0500, t1);
    wait_idle(0);
    chk("sat_one", rd(16'h0500), 16'd9);
    chk("sat_ten", rd(16'h0501), 16'd9);
    chk("sat_hun", rd(16'h0502), 16'd9);
    accept(10'd0, 16'h0510, t1);
    wait_idle(0);
    chk("zero_one", rd(16'h0510), 16'd0);
    chk("zero_ten", rd(16'h0511), 16'd0);
    chk("zero_hun", rd(16'h0512), 16'd0);

    // Window closed for 4 cycles after the ones write.
    wlog.delete();
    accept(10'd846, 16'h0520, t1);
    wait_idle(4);
    chk("drop_nwrites", wlog.size(), 3);
    if (wlog.size() == 3) begin
      chk("drop_ten_gap", wlog[1].e - wlog[0].e, 5);
      chk("drop_hun_gap", wlog[2].e - wlog[1].e, 1);
      chk("drop_ten_edge", wlog[1].e, t1 + 16);
      chk("drop_order", {wlog[0].d[3:0], wlog[1].d[3:0], wlog[2].d[3:0]}, 12'h648);
    end

    // Address wrap.
    accept(10'd123, 16'hFFFF, t1);
    wait_idle(0);
    chk("wrap_ffff", rd(16'hFFFF), 16'd3);
    chk("wrap_0000", rd(16'h0000), 16'd2);
    chk("wrap_0001", rd(16'h0001), 16'd1);

    // Second value held while busy.
    accept(10'd500, 16'h0700, t1);
    accept(10'd58, 16'h0710, t2);
    wait_idle(0);
    chk("held_gap", t2 - t1, 15);
    chk("held_a_one", rd(16'h0700), 16'd0);
    chk("held_a_hun", rd(16'h0702), 16'd5);
    chk("held_b_one", rd(16'h0710), 16'd8);
    chk("held_b_ten", rd(16'h0711), 16'd5);
    chk("held_b_hun", rd(16'h0712), 16'd0);

    // Reset during CONVERT.
    accept(10'd777, 16'h0800, t1);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("rst_conv_ready", value_ready, 1'b1);
    repeat (20) step();
    chk("rst_conv_one", rd(16'h0800), 16'hDEAD);
    chk("rst_conv_hun", rd(16'h0802), 16'hDEAD);

    // Reset right after the ones write.
    accept(10'd456, 16'h0900, t1);
    repeat (11) step();
    reset = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    step();
    chk("rst_wr_ready", value_ready, 1'b1);
    repeat (20) step();
    chk("rst_wr_one", rd(16'h0900), 16'd6);
    chk("rst_wr_ten", rd(16'h0901), 16'hDEAD);
    chk("rst_wr_hun", rd(16'h0902), 16'hDEAD);

    // Recovery after reset.
    accept(10'd999, 16'h0A00, t1);
    wait_idle(0);
    chk("recover_hun", rd(16'h0A02), 16'd9);

    chk_en = 0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
